// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS subset core: PC, instruction ROM, register file, ALU and data RAM.
// Each instruction fetches, decodes, executes and commits on one rising clock edge.

module mips_regfile (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b
);
  logic [31:0] registers [0:31];

  // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : registers[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : registers[i_raddr_b];
endmodule

module mips_single_cycle_cpu #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_instr
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
    OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  function automatic logic [IMEM_WORDS-1:0][31:0] rom_init();
    logic [IMEM_WORDS-1:0][31:0] img;
    img    = '0;
    img[0] = 32'h2001000A;
    img[1] = 32'h20020014;
    img[2] = 32'h00221820;
    img[3] = 32'h2004001E;
    img[4] = 32'h10640001;
    img[5] = 32'h20050002;
    img[6] = 32'h20050001;
    img[7] = 32'h1000FFFF;
    return img;
  endfunction

  logic [IMEM_WORDS-1:0][31:0] r_rom = rom_init();
  logic [31:0]                 r_dmem [0:DMEM_WORDS-1];
  logic [31:0]                 r_pc;

  logic [31:0] w_instr, w_simm, w_rs_data, w_rt_data, w_alu_b, w_alu_result;
  logic [31:0] w_wdata, w_pc_plus4, w_next_pc;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dst;
  logic        w_reg_write, w_alu_src_imm, w_mem_to_reg, w_mem_write;
  logic        w_branch, w_jump, w_unused;
  alu_op_e     w_alu_op;

  assign w_instr  = r_rom[r_pc[IAW+1:2]];
  assign w_opcode = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_funct  = w_instr[5:0];
  assign w_simm   = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_unused = ^w_instr[10:6];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_reg_write   = 1'b0;
    w_dst         = w_rt;
    w_alu_src_imm = 1'b0;
    w_alu_op      = ALU_ADD;
    w_mem_to_reg  = 1'b0;
    w_mem_write   = 1'b0;
    w_branch      = 1'b0;
    w_jump        = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_dst = w_rd;
        case (w_funct)
          FN_ADD:  begin w_reg_write = 1'b1; w_alu_op = ALU_ADD; end
          FN_SUB:  begin w_reg_write = 1'b1; w_alu_op = ALU_SUB; end
          FN_AND:  begin w_reg_write = 1'b1; w_alu_op = ALU_AND; end
          FN_OR:   begin w_reg_write = 1'b1; w_alu_op = ALU_OR;  end
          FN_SLT:  begin w_reg_write = 1'b1; w_alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin w_reg_write = 1'b1; w_alu_src_imm = 1'b1; end
      OP_LW:   begin w_reg_write = 1'b1; w_alu_src_imm = 1'b1; w_mem_to_reg = 1'b1; end
      OP_SW:   begin w_alu_src_imm = 1'b1; w_mem_write = 1'b1; end
      OP_BEQ:  w_branch = 1'b1;
      OP_J:    w_jump = 1'b1;
      default: ;
    endcase
  end

  mips_regfile rf_inst (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_reg_write),
    .i_waddr   (w_dst),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rt_data)
  );

  assign w_alu_b = w_alu_src_imm ? w_simm : w_rt_data;

  always_comb begin
    w_alu_result = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_result = w_rs_data + w_alu_b;
      ALU_SUB: w_alu_result = w_rs_data - w_alu_b;
      ALU_AND: w_alu_result = w_rs_data & w_alu_b;
      ALU_OR:  w_alu_result = w_rs_data | w_alu_b;
      ALU_SLT: w_alu_result = {31'd0, $signed(w_rs_data) < $signed(w_alu_b)};
      default: w_alu_result = '0;
    endcase
  end

  assign w_wdata    = w_mem_to_reg ? r_dmem[w_alu_result[DAW+1:2]] : w_alu_result;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_jump)
      w_next_pc = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
    else if (w_branch && (w_rs_data == w_rt_data))
      w_next_pc = w_pc_plus4 + {w_simm[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= '0;
    else     r_pc <= w_next_pc;
  end

  // NOTE: data RAM keeps its contents across reset; rst only blocks the in-flight store.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_write) r_dmem[w_alu_result[DAW+1:2]] <= w_rt_data;
  end

  assign dbg_pc    = r_pc;
  assign dbg_instr = w_instr;
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Scoreboard bench: an instruction-level model predicts each cycle's PC/instruction and the
// final register file for directed and random programs loaded into the core's ROM.

module tb_mips_single_cycle_cpu;
  logic        clk;
  logic        rst;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_instr;

  mips_single_cycle_cpu dut (
    .clk       (clk),
    .rst       (rst),
    .dbg_pc    (dbg_pc),
    .dbg_instr (dbg_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] prog   [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_ram  [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: the core presents one architectural state per cycle while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: core ran at pc 0x%08h with no expected entry", dbg_pc);
        end else begin
          e = sb_q.pop_front();
          check("pc", dbg_pc, e.pc);
          check("instr", dbg_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: interprets each instruction word by the ISA rules.
  task automatic model_run(input int ncycles);
    logic [31:0] pc, ins, a, b, simm, addr, nxt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int c = 0; c < ncycles; c++) begin
      ins = prog[(pc >> 2) % 64];
      sb_q.push_back('{pc: pc, instr: ins});
      op   = ins[31:26];
      rs   = ins[25:21];
      rt   = ins[20:16];
      rd   = ins[15:11];
      a    = m_regs[rs];
      b    = m_regs[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      addr = a + simm;
      nxt  = pc + 32'd4;
      case (op)
        6'h00: case (ins[5:0])
          6'h20: if (rd != 0) m_regs[rd] = a + b;
          6'h22: if (rd != 0) m_regs[rd] = a - b;
          6'h24: if (rd != 0) m_regs[rd] = a & b;
          6'h25: if (rd != 0) m_regs[rd] = a | b;
          6'h2A: if (rd != 0) m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: if (rt != 0) m_regs[rt] = addr;
        6'h23: if (rt != 0) m_regs[rt] = m_ram[(addr >> 2) % 64];
        6'h2B: m_ram[(addr >> 2) % 64] = b;
        6'h04: if (a == b) nxt = pc + 32'd4 + simm * 4;
        6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] w;
    int          k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 16)) - 8);
    k   = int'($urandom_range(0, 11));
    case (k)
      0:       w = enc_r(rs, rt, rd, 6'h20);
      1:       w = enc_r(rs, rt, rd, 6'h22);
      2:       w = enc_r(rs, rt, rd, 6'h24);
      3:       w = enc_r(rs, rt, rd, 6'h25);
      4:       w = enc_r(rs, rt, rd, 6'h2A);
      5, 6:    w = enc_i(6'h08, rs, rt, imm);
      7:       w = enc_i(6'h23, rs, rt, imm);
      8:       w = enc_i(6'h2B, rs, rt, imm);
      9:       w = enc_i(6'h04, rs, rt, 16'(int'($urandom_range(0, 6)) - 3));
      10: begin
        tgt = 26'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) tgt = tgt | (26'($urandom) & 26'h3FFFFC0);
        w = {6'h02, tgt};
      end
      default: w = ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)} : enc_r(rs, rt, rd, 6'h00);
    endcase
    return w;
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.r_rom[i] = prog[i];
  endtask

  // Model first (fills the scoreboard), then release reset and let the core run.
  task automatic run_and_check_regs(input string tag, input int ncycles);
    model_run(ncycles);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (ncycles) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_reg%0d", tag, i), dut.rf_inst.registers[i], m_regs[i]);
  endtask

  task automatic end_run(input string tag);
    int nz;
    rst = 1'b1;
    #1;
    check({tag, "_async_rst_pc"}, dbg_pc, 32'd0);
    check({tag, "_rst_instr"}, dbg_instr, prog[0]);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf_inst.registers[i] !== 32'd0) nz++;
    check({tag, "_rst_regs_nonzero"}, 32'(nz), 32'd0);
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dut.r_dmem[i] = 32'd0;
      m_ram[i]      = 32'd0;
      prog[i]       = 32'd0;
    end
    prog[0] = 32'h2001000A; prog[1] = 32'h20020014; prog[2] = 32'h00221820;
    prog[3] = 32'h2004001E; prog[4] = 32'h10640001; prog[5] = 32'h20050002;
    prog[6] = 32'h20050001; prog[7] = 32'h1000FFFF;

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", dbg_pc, 32'd0);
    check("reset_instr", dbg_instr, 32'h2001000A);

    // Built-in program, untouched ROM.
    run_and_check_regs("dflt", 20);
    check("dflt_r1", dut.rf_inst.registers[1], 32'd10);
    check("dflt_r2", dut.rf_inst.registers[2], 32'd20);
    check("dflt_r3", dut.rf_inst.registers[3], 32'd30);
    check("dflt_r4", dut.rf_inst.registers[4], 32'd30);
    check("dflt_r5", dut.rf_inst.registers[5], 32'd1);
    check("dflt_halt_pc", dbg_pc, 32'h1C);
    end_run("dflt");

    // $0 protection.
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0] = 32'h20000005;
    prog[1] = 32'h00003020;
    load_prog();
    run_and_check_regs("zero", 4);
    check("zero_r0", dut.rf_inst.registers[0], 32'd0);
    check("zero_r6", dut.rf_inst.registers[6], 32'd0);
    end_run("zero");

    // Store then load through data RAM.
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0] = 32'h20010007;
    prog[1] = 32'hAC010008;
    prog[2] = 32'h8C070008;
    load_prog();
    run_and_check_regs("mem", 4);
    check("mem_r7", dut.rf_inst.registers[7], 32'd7);
    end_run("mem");

    // Signed compare and subtraction wrap.
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0] = 32'h2001FFFF;
    prog[1] = 32'h0020102A;
    prog[2] = 32'h00011822;
    load_prog();
    run_and_check_regs("arith", 4);
    check("arith_r2", dut.rf_inst.registers[2], 32'd1);
    check("arith_r3", dut.rf_inst.registers[3], 32'd1);
    end_run("arith");

    // Jump to word 0x10.
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0] = 32'h08000010;
    load_prog();
    run_and_check_regs("jump", 1);
    check("jump_pc", dbg_pc, 32'h40);
    end_run("jump");

    // Random programs; data RAM carries over between runs in both model and core.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 64; i++) prog[i] = rand_instr();
      load_prog();
      run_and_check_regs($sformatf("rnd%0d", p), 40);
      end_run($sformatf("rnd%0d", p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
